fifo_stream_tx: RTL and testbench
=================================

// Module: fifo_stream_tx
// PURPOSE
//  Read side of a peek-style sync FIFO (head word visible on fifo_data, one-cycle pop strobe).
//  Drains FIFO words into a valid/ready master stream and frames them into packets of
//  cfg_pkt_len beats with tlast and a per-packet destination. Sits between the result FIFO
//  and the NoC/AXI-S egress port of the rtl_add design.
// PARAMETERS
//  DATA_WIDTH  8  width of FIFO word and m_tdata
//  LEN_WIDTH   8  width of cfg_pkt_len and the internal beat counter
//  DEST_WIDTH  4  width of cfg_dest / m_tdest
//  CNT_WIDTH   16 width of pkt_count
// PORTS
//  clk          in   1           clock, all logic on rising edge
//  rst          in   1           synchronous reset, ACTIVE-LOW
//  fifo_data    in   DATA_WIDTH  FIFO head word (valid when fifo_empty=0)
//  fifo_empty   in   1           FIFO empty flag
//  fifo_r_enable out 1           pop strobe to FIFO, combinational
//  tx_enable    in   1           permit start of new packets
//  cfg_pkt_len  in   LEN_WIDTH   beats per packet; sampled at packet start; 0 => 1
//  cfg_dest     in   DEST_WIDTH  destination; sampled at packet start
//  m_tvalid     out  1           output beat valid
//  m_tready     in   1           downstream ready
//  m_tdata      out  DATA_WIDTH  output beat data
//  m_tlast      out  1           last beat of packet
//  m_tdest      out  DEST_WIDTH  packet destination, constant across a packet
//  busy         out  1           packet in progress or beat pending
//  pkt_count    out  CNT_WIDTH   packets fully accepted downstream, wraps
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, beat_cnt=0, len_q=0, m_tvalid=0, m_tdata=0,
//   m_tlast=0, m_tdest=0, pkt_count=0; busy=0. Reset wins over every other event,
//   including mid-packet; partial packet is abandoned, FIFO contents untouched.
//  Output register: single stage. slot_free = !m_tvalid || m_tready.
//  load = slot_free && !fifo_empty && (state==ACTIVE || tx_enable).
//  fifo_r_enable = load (never asserted while fifo_empty=1, never while rst=0).
//  On load: m_tdata<=fifo_data, m_tvalid<=1. Else if m_tready: m_tvalid<=0.
//  Latency: FIFO non-empty at cycle N -> m_tvalid=1 at N+1. Throughput 1 beat/cycle with
//   m_tready held high.
//  Stream rules: while m_tvalid=1 && m_tready=0, m_tdata/m_tlast/m_tdest hold stable.
//   m_tvalid never drops without a handshake.
//  FSM (2 states):
//   IDLE: on load -> len_q<=max(cfg_pkt_len,1), m_tdest<=cfg_dest, beat_cnt<=1;
//         if len==1: m_tlast<=1, stay IDLE; else m_tlast<=0, go ACTIVE.
//         tx_enable=0 -> no load.
//   ACTIVE: on load -> beat_cnt<=beat_cnt+1; m_tlast<=(beat_cnt==len_q-1);
//         on loading the last beat -> beat_cnt<=0, go IDLE. tx_enable ignored (packet
//         always completes). cfg_* changes ignored until next IDLE load.
//  Widths: beat_cnt is LEN_WIDTH bits; max packet 2^LEN_WIDTH-1 beats; no overflow.
//  pkt_count increments by 1 on m_tvalid&&m_tready&&m_tlast; wraps 2^CNT_WIDTH-1 -> 0.
//  busy = (state==ACTIVE) || m_tvalid.
//  FIFO underrun mid-packet: m_tvalid drops after last handshake, state stays ACTIVE,
//   resumes on next non-empty cycle; no gap filling.
//  Simultaneous handshake+load in same cycle: new beat replaces old, m_tvalid stays 1.
// STRUCTURE
//  Shared header stream_tx_defs.vh: state encodings ST_IDLE=1'b0, ST_ACTIVE=1'b1,
//   default width localparams. No sub-module; FIFO is instantiated by the parent.
//  Flat: one FSM/counter always block, one output-register always block, assigns.
// TESTING (bench instantiates fifo DEPTH=8 feeding this block)
//  1 Reset: hold rst=0 3 cycles with FIFO non-empty -> all outputs 0, fifo_r_enable=0.
//  2 Push 0x11..0x14, len=4, dest=3, tready=1 -> 4 beats back-to-back, tlast only on
//    0x14, tdest=3 all beats, pkt_count=1, busy=0 one cycle after last handshake.
//  3 Backpressure: len=2, tready toggles 0,0,1,0,1 -> data/tlast stable while stalled,
//    no FIFO pop while stalled, exactly 2 beats delivered in order.
//  4 len=0 and len=1, push 0xA0,0xA1 -> two 1-beat packets, tlast=1 each, pkt_count+=2.
//  5 tx_enable dropped after 1st beat of len=3 packet -> packet completes (3 beats),
//    next packet does not start until tx_enable=1; cfg_dest change mid-packet ignored.
//  6 Reset mid-packet after 2 of 4 beats -> outputs cleared; post-reset next word starts
//    a fresh packet with beat_cnt=1 and freshly sampled cfg.

Source files
------------

// File: rtl/fifo_stream_tx_pkg.sv
// rtl/fifo_stream_tx_pkg.sv - shared types and defaults for the FIFO-to-stream packetiser
//
// Purpose: FSM state encoding, default widths and a small sizing helper used by
// fifo_stream_tx and its companion peek FIFO.
// Ports: none (package).

package fifo_stream_tx_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int DEF_DEST_WIDTH = 4;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // Address width for a memory of n entries; never returns 0 so a 1-entry
  // FIFO still gets a legal one-bit pointer.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_stream_tx_fifo.sv
// rtl/fifo_stream_tx_fifo.sv - peek-style synchronous FIFO feeding fifo_stream_tx
//
// Purpose: single-clock FIFO whose head word is always visible on rd_data_o;
// a one-cycle rd_en_i pulse pops it. Writes while full and reads while empty
// are ignored.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low reset (empties the FIFO)
//   wr_en_i    push strobe
//   wr_data_i  word to push
//   full_o     no free entry
//   rd_en_i    pop strobe
//   rd_data_o  head word, valid while empty_o=0
//   empty_o    no stored entry
//   count_o    number of stored entries

module fifo_stream_tx_fifo
  import fifo_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  output logic                         full_o,
  input  logic                         rd_en_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_wr, do_rd;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap keeps non power-of-two depths correct.
    if (do_wr) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    end
    if (do_rd) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fifo_stream_tx.sv
// rtl/fifo_stream_tx.sv - drains a peek FIFO into a framed valid/ready packet stream
//
// Purpose: pops words from a peek-style FIFO into a single-stage output
// register and frames them into packets of cfg_pkt_len beats with tlast and a
// per-packet destination.
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   fifo_data      FIFO head word
//   fifo_empty     FIFO empty flag
//   fifo_r_enable  pop strobe to FIFO (combinational)
//   tx_enable      permits the start of new packets
//   cfg_pkt_len    beats per packet, sampled at packet start, 0 means 1
//   cfg_dest       destination, sampled at packet start
//   m_tvalid/m_tready/m_tdata/m_tlast/m_tdest  master stream
//   busy           packet in progress or beat pending
//   pkt_count      packets fully accepted downstream, wraps

module fifo_stream_tx
  import fifo_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int DEST_WIDTH = DEF_DEST_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_r_enable,
  input  logic                  tx_enable,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [DEST_WIDTH-1:0] m_tdest,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  tx_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  tlast_q, tlast_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;

  logic                  slot_free;
  logic                  load;
  logic                  last_beat;
  logic [LEN_WIDTH-1:0]  eff_len;

  // The output slot can take a new word when empty or being drained this cycle.
  assign slot_free = !tvalid_q || m_tready;

  // A started packet always runs to completion; tx_enable only gates new ones.
  // Gating with rst keeps the FIFO untouched while reset is held.
  assign load = rst && slot_free && !fifo_empty &&
                ((state_q == ST_ACTIVE) || tx_enable);

  assign fifo_r_enable = load;
  assign eff_len       = (cfg_pkt_len == '0) ? LEN_ONE : cfg_pkt_len;
  assign last_beat     = (beat_cnt_q == (len_q - LEN_ONE));

  // Packet framing: beat counter, latched length/destination, tlast.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    tlast_d    = tlast_q;
    tdest_d    = tdest_q;
    if (load) begin
      case (state_q)
        ST_IDLE: begin
          len_d      = eff_len;
          tdest_d    = cfg_dest;
          beat_cnt_d = LEN_ONE;
          if (eff_len == LEN_ONE) begin
            tlast_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tlast_d = 1'b0;
            state_d = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          tlast_d = last_beat;
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      len_q      <= '0;
      tlast_q    <= 1'b0;
      tdest_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      tlast_q    <= tlast_d;
      tdest_q    <= tdest_d;
    end
  end

  // Output register and packet counter. A load in the same cycle as a
  // handshake replaces the accepted beat, so tvalid stays high.
  always_comb begin
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    pkt_count_d = pkt_count_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = fifo_data;
    end else if (m_tready) begin
      tvalid_d = 1'b0;
    end
    if (tvalid_q && m_tready && tlast_q) begin
      pkt_count_d = pkt_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      pkt_count_q <= '0;
    end else begin
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign m_tvalid  = tvalid_q;
  assign m_tdata   = tdata_q;
  assign m_tlast   = tlast_q;
  assign m_tdest   = tdest_q;
  assign pkt_count = pkt_count_q;
  assign busy      = (state_q == ST_ACTIVE) || tvalid_q;

endmodule

// File: tb/tb_fifo_stream_tx.sv
// tb/tb_fifo_stream_tx.sv - self-checking bench for fifo_stream_tx behind an 8-deep FIFO

module tb_fifo_stream_tx;

  logic        clk = 1'b0;
  logic        rst_n, fifo_rst_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        fifo_full, fifo_empty, fifo_r_enable;
  logic [3:0]  fifo_count;
  logic [7:0]  fifo_data;
  logic        tx_enable;
  logic [7:0]  cfg_pkt_len;
  logic [3:0]  cfg_dest;
  logic        m_tvalid, m_tready, m_tlast, busy;
  logic [7:0]  m_tdata;
  logic [3:0]  m_tdest;
  logic [15:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] cap_data[$];
  logic       cap_last[$];
  logic [3:0] cap_dest[$];
  int         cap_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_stream_tx_fifo #(.DATA_WIDTH(8), .DEPTH(8)) u_fifo (
    .clk_i(clk), .rst_ni(fifo_rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(fifo_full), .rd_en_i(fifo_r_enable), .rd_data_o(fifo_data),
    .empty_o(fifo_empty), .count_o(fifo_count)
  );

  fifo_stream_tx #(.DATA_WIDTH(8), .LEN_WIDTH(8), .DEST_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_r_enable(fifo_r_enable), .tx_enable(tx_enable), .cfg_pkt_len(cfg_pkt_len),
    .cfg_dest(cfg_dest), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tdest(m_tdest), .busy(busy), .pkt_count(pkt_count)
  );

  task automatic do_reset();
    rst_n = 1'b0; fifo_rst_n = 1'b0; wr_en = 1'b0; tx_enable = 1'b0; m_tready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; fifo_rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Record beats seen as valid&&ready at the falling edge (accepted at the next rising edge).
  task automatic collect(input int n, input int budget);
    cap_data.delete(); cap_last.delete(); cap_dest.delete(); cap_cyc.delete();
    for (int c = 0; c < budget && cap_data.size() < n; c++) begin
      @(negedge clk);
      if (m_tvalid && m_tready) begin
        cap_data.push_back(m_tdata); cap_last.push_back(m_tlast);
        cap_dest.push_back(m_tdest); cap_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fifo_rst_n = 1'b0; wr_en = 1'b0; wr_data = '0;
    tx_enable = 1'b1; m_tready = 1'b1; cfg_pkt_len = 8'd1; cfg_dest = 4'd0;
    @(posedge clk); #1;
    fifo_rst_n = 1'b1;
    push(8'h55);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %0b want 0", m_tvalid); end
    n_checks++; if (m_tdata !== 8'h00) begin n_fail++; $display("FAIL reset_tdata got %0h want 0", m_tdata); end
    n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %0b want 0", m_tlast); end
    n_checks++; if (m_tdest !== 4'h0) begin n_fail++; $display("FAIL reset_tdest got %0h want 0", m_tdest); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    n_checks++; if (fifo_r_enable !== 1'b0) begin n_fail++; $display("FAIL reset_r_enable got %0b want 0", fifo_r_enable); end
    n_checks++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_kept got empty=%0b want 0", fifo_empty); end
    rst_n = 1'b1;
    collect(1, 6);
    n_checks++; if (cap_data.size() != 1) begin n_fail++; $display("FAIL reset_release_beats got %0d want 1", cap_data.size()); end
    if (cap_data.size() == 1) begin
      n_checks++; if (cap_data[0] !== 8'h55 || cap_last[0] !== 1'b1) begin n_fail++; $display("FAIL reset_release_beat got %0h/%0b want 55/1", cap_data[0], cap_last[0]); end
    end
    @(posedge clk); #1;
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL reset_release_count got %0d want 1", pkt_count); end
  endtask

  task automatic test_basic_packet();
    int t0;
    do_reset();
    cfg_pkt_len = 8'd4; cfg_dest = 4'd3; m_tready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
    @(negedge clk);
    tx_enable = 1'b1;
    t0 = cyc;
    #1;
    n_checks++; if (fifo_r_enable !== 1'b1) begin n_fail++; $display("FAIL basic_pop got %0b want 1", fifo_r_enable); end
    n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid got %0b want 0", m_tvalid); end
    collect(4, 12);
    n_checks++; if (cap_data.size() != 4) begin n_fail++; $display("FAIL basic_beats got %0d want 4", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      n_checks++; if (cap_data[i] !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL basic_data[%0d] got %0h want %0h", i, cap_data[i], 8'(8'h11 + i)); end
      n_checks++; if (cap_last[i] !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d] got %0b want %0b", i, cap_last[i], (i == 3)); end
      n_checks++; if (cap_dest[i] !== 4'd3) begin n_fail++; $display("FAIL basic_dest[%0d] got %0d want 3", i, cap_dest[i]); end
      n_checks++; if (cap_cyc[i] != t0 + 1 + i) begin n_fail++; $display("FAIL basic_timing[%0d] got cycle %0d want %0d", i, cap_cyc[i], t0 + 1 + i); end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %0b want 0", busy); end
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL basic_pkt_count got %0d want 1", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic pat [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int hs;
    logic [7:0] exp_d;
    do_reset();
    cfg_pkt_len = 8'd2; cfg_dest = 4'd5;
    push(8'h21); push(8'h22);
    tx_enable = 1'b1;
    @(posedge clk); #1;
    hs = 0;
    for (int s = 0; s < 5; s++) begin
      m_tready = pat[s];
      @(negedge clk);
      exp_d = 8'(8'h21 + hs);
      n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_valid step%0d got %0b want 1", s, m_tvalid); end
      n_checks++; if (m_tdata !== exp_d || m_tlast !== (hs == 1) || m_tdest !== 4'd5) begin
        n_fail++; $display("FAIL bp_beat step%0d got %0h/%0b/%0d want %0h/%0b/5", s, m_tdata, m_tlast, m_tdest, exp_d, (hs == 1));
      end
      if (!m_tready) begin
        n_checks++; if (fifo_r_enable !== 1'b0) begin n_fail++; $display("FAIL bp_stall_pop step%0d got %0b want 0", s, fifo_r_enable); end
      end else if (m_tvalid) begin
        hs++;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (hs != 2) begin n_fail++; $display("FAIL bp_beats got %0d want 2", hs); end
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL bp_pkt_count got %0d want 1", pkt_count); end
    n_checks++; if (m_tvalid !== 1'b0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL bp_drained got valid=%0b empty=%0b want 0/1", m_tvalid, fifo_empty); end
  endtask

  task automatic test_len_zero_one();
    do_reset();
    cfg_pkt_len = 8'd0; cfg_dest = 4'd1; m_tready = 1'b1;
    push(8'hA0); push(8'hA1);
    tx_enable = 1'b1;
    @(posedge clk); #1;
    cfg_pkt_len = 8'd1; cfg_dest = 4'd2;
    collect(2, 8);
    n_checks++; if (cap_data.size() != 2) begin n_fail++; $display("FAIL len01_beats got %0d want 2", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      n_checks++; if (cap_data[i] !== 8'(8'hA0 + i) || cap_last[i] !== 1'b1 || cap_dest[i] !== 4'(1 + i)) begin
        n_fail++; $display("FAIL len01_beat[%0d] got %0h/%0b/%0d want %0h/1/%0d", i, cap_data[i], cap_last[i], cap_dest[i], 8'(8'hA0 + i), 1 + i);
      end
    end
    @(posedge clk); #1;
    n_checks++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL len01_pkt_count got %0d want 2", pkt_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len01_busy got %0b want 0", busy); end
  endtask

  task automatic test_tx_enable_and_underrun();
    do_reset();
    cfg_pkt_len = 8'd3; cfg_dest = 4'd2; m_tready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h31 + i));
    tx_enable = 1'b1;
    @(posedge clk); #1;
    tx_enable = 1'b0; cfg_dest = 4'd9; cfg_pkt_len = 8'd7;
    collect(3, 10);
    n_checks++; if (cap_data.size() != 3) begin n_fail++; $display("FAIL txen_beats got %0d want 3", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      n_checks++; if (cap_data[i] !== 8'(8'h31 + i) || cap_last[i] !== (i == 2) || cap_dest[i] !== 4'd2) begin
        n_fail++; $display("FAIL txen_beat[%0d] got %0h/%0b/%0d want %0h/%0b/2", i, cap_data[i], cap_last[i], cap_dest[i], 8'(8'h31 + i), (i == 2));
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (m_tvalid !== 1'b0 || fifo_r_enable !== 1'b0) begin n_fail++; $display("FAIL txen_hold%0d got valid=%0b pop=%0b want 0/0", i, m_tvalid, fifo_r_enable); end
    end
    n_checks++; if (pkt_count !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL txen_idle got count=%0d busy=%0b want 1/0", pkt_count, busy); end
    tx_enable = 1'b1;
    collect(2, 8);
    n_checks++; if (cap_data.size() != 2) begin n_fail++; $display("FAIL under_beats got %0d want 2", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      n_checks++; if (cap_data[i] !== 8'(8'h34 + i) || cap_last[i] !== 1'b0 || cap_dest[i] !== 4'd9) begin
        n_fail++; $display("FAIL under_beat[%0d] got %0h/%0b/%0d want %0h/0/9", i, cap_data[i], cap_last[i], cap_dest[i], 8'(8'h34 + i));
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL under_gap got valid=%0b busy=%0b want 0/1", m_tvalid, busy); end
    tx_enable = 1'b0;
    push(8'h36);
    collect(1, 6);
    n_checks++; if (cap_data.size() != 1) begin n_fail++; $display("FAIL under_resume_beats got %0d want 1", cap_data.size()); end
    if (cap_data.size() == 1) begin
      n_checks++; if (cap_data[0] !== 8'h36 || cap_last[0] !== 1'b0 || cap_dest[0] !== 4'd9) begin
        n_fail++; $display("FAIL under_resume got %0h/%0b/%0d want 36/0/9", cap_data[0], cap_last[0], cap_dest[0]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    cfg_pkt_len = 8'd4; cfg_dest = 4'd6; m_tready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h41 + i));
    tx_enable = 1'b1;
    collect(2, 8);
    n_checks++; if (cap_data.size() != 2) begin n_fail++; $display("FAIL midrst_pre_beats got %0d want 2", cap_data.size()); end
    @(posedge clk); #1;
    rst_n = 1'b0; cfg_pkt_len = 8'd2; cfg_dest = 4'hA;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0 || m_tdest !== 4'h0) begin
      n_fail++; $display("FAIL midrst_outputs got %0b/%0h/%0b/%0h want 0/0/0/0", m_tvalid, m_tdata, m_tlast, m_tdest);
    end
    n_checks++; if (busy !== 1'b0 || pkt_count !== 16'd0 || fifo_r_enable !== 1'b0) begin
      n_fail++; $display("FAIL midrst_status got busy=%0b count=%0d pop=%0b want 0/0/0", busy, pkt_count, fifo_r_enable);
    end
    n_checks++; if (fifo_count !== 4'd2) begin n_fail++; $display("FAIL midrst_fifo_kept got %0d want 2", fifo_count); end
    rst_n = 1'b1;
    collect(2, 8);
    n_checks++; if (cap_data.size() != 2) begin n_fail++; $display("FAIL midrst_post_beats got %0d want 2", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      n_checks++; if (cap_data[i] !== 8'(8'h44 + i) || cap_last[i] !== (i == 1) || cap_dest[i] !== 4'hA) begin
        n_fail++; $display("FAIL midrst_post[%0d] got %0h/%0b/%0h want %0h/%0b/a", i, cap_data[i], cap_last[i], cap_dest[i], 8'(8'h44 + i), (i == 1));
      end
    end
    @(posedge clk); #1;
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL midrst_pkt_count got %0d want 1", pkt_count); end
  endtask

  // Random data, lengths, destinations, backpressure and tx_enable against a
  // queue model: beat i of a round is last when i mod len == len-1.
  task automatic test_random_traffic();
    int exp_pkts;
    do_reset();
    exp_pkts = 0;
    for (int r = 0; r < 6; r++) begin
      int         len, eff, npk, total, got;
      logic [3:0] dst;
      logic [7:0] words[$];
      logic       prev_stall;
      logic [7:0] pd;
      logic       pl;
      len = $urandom_range(0, 6);
      eff = (len == 0) ? 1 : len;
      npk = $urandom_range(1, 4);
      total = npk * eff;
      dst = 4'($urandom_range(0, 15));
      words.delete();
      for (int i = 0; i < total; i++) words.push_back(8'($urandom_range(0, 255)));
      cfg_pkt_len = 8'(len); cfg_dest = dst;
      got = 0;
      fork
        begin
          int k = 0;
          for (int t = 0; t < 2000 && k < total; t++) begin
            @(posedge clk); #1;
            if (!fifo_full && $urandom_range(0, 3) != 0) begin
              wr_en = 1'b1; wr_data = words[k]; k++;
            end else begin
              wr_en = 1'b0;
            end
          end
          @(posedge clk); #1;
          wr_en = 1'b0;
        end
        begin
          prev_stall = 1'b0; pd = '0; pl = 1'b0;
          for (int c = 0; c < 600 && got < total; c++) begin
            @(posedge clk); #1;
            m_tready = ($urandom_range(0, 3) != 0);
            tx_enable = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (prev_stall) begin
              n_checks++; if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tlast !== pl) begin
                n_fail++; $display("FAIL rnd_stall r%0d got %0b/%0h/%0b want 1/%0h/%0b", r, m_tvalid, m_tdata, m_tlast, pd, pl);
              end
            end
            if (m_tvalid && m_tready) begin
              n_checks++; if (m_tdata !== words[got] || m_tlast !== ((got % eff) == eff - 1) || m_tdest !== dst) begin
                n_fail++; $display("FAIL rnd_beat r%0d i%0d got %0h/%0b/%0h want %0h/%0b/%0h", r, got, m_tdata, m_tlast, m_tdest, words[got], ((got % eff) == eff - 1), dst);
              end
              got++;
            end
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata; pl = m_tlast;
          end
          @(posedge clk); #1;
        end
      join
      exp_pkts += npk;
      n_checks++; if (got != total) begin n_fail++; $display("FAIL rnd_count r%0d got %0d beats want %0d", r, got, total); end
      n_checks++; if (pkt_count !== 16'(exp_pkts)) begin n_fail++; $display("FAIL rnd_pkt_count r%0d got %0d want %0d", r, pkt_count, exp_pkts); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_packet();
    test_backpressure();
    test_len_zero_one();
    test_tx_enable_and_underrun();
    test_reset_mid_packet();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
